// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Request/response bundle between one requester and the data-memory arbiter.
//   One instance per requester (m0 = core load/store unit, m1 = DMA/debug).
//
//   Signals
//     req     requester -> arbiter  request, held high until gnt
//     we      requester -> arbiter  1 = write, 0 = read
//     addr    requester -> arbiter  byte address, bits [1:0] ignored
//     wdata   requester -> arbiter  write data
//     be      requester -> arbiter  byte enables for writes
//     gnt     arbiter -> requester  one-cycle pulse, request accepted
//     rvalid  arbiter -> requester  one-cycle pulse, response available
//     err     arbiter -> requester  qualifies rvalid: address out of range
//     rdata   arbiter -> requester  read data, valid with rvalid
//
//   Modports
//     master  the requester side
//     slave   the arbiter side
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int wid = 32
);
  logic           req;
  logic           we;
  logic [wid-1:0] addr;
  logic [wid-1:0] wdata;
  logic [3:0]     be;
  logic           gnt;
  logic           rvalid;
  logic           err;
  logic [wid-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory (synchronous write, combinational read)
//   between two requesters with round-robin arbitration and one transaction
//   in flight. Sub-word stores become a read-modify-write; word indices at or
//   beyond the memory depth get an error response without touching memory.
//
//   Parameters
//     wid   data/address width (byte lanes assume 32-bit words, 4 enables)
//     dep   memory depth in words, valid word index 0..dep-1
//
//   Ports
//     clk        clock, all state on the rising edge
//     rst_n      synchronous reset, active low
//     m0         requester 0 bundle (arbiter side), core load/store unit
//     m1         requester 1 bundle (arbiter side), DMA/debug
//     mem_addr   byte address to memory
//     mem_wd     write data to memory
//     mem_we     memory write enable, one cycle per write
//     mem_rd     combinational read data from memory
//
//   Timing (gnt in cycle T)
//     read / full write / empty-enable write / error : rvalid at T+2
//     partial write (read in T+1, write in T+2)       : rvalid at T+3
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int wid = 32,
  parameter int dep = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  output logic [wid-1:0] mem_addr,
  output logic [wid-1:0] mem_wd,
  output logic           mem_we,
  input  logic [wid-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  // Depth expressed in the width of the word index for an unsigned compare.
  localparam logic [wid-3:0] dep_idx = (wid-2)'(dep);

  state_t         state_reg, state_next;

  // Latched transaction
  logic           rr_last_reg;   // owner of the most recent grant
  logic           owner_reg;     // 0 = m0, 1 = m1
  logic           we_reg;
  logic [wid-1:0] addr_reg;
  logic [wid-1:0] wdata_reg;
  logic [3:0]     be_reg;
  logic [wid-1:0] merge_reg;     // old memory word for read-modify-write

  // Arbitration
  logic [1:0]     req_vec;
  logic           grant;
  logic           grant_owner;
  logic [1:0]     gnt_vec;

  // Winner's request fields
  logic           sel_we;
  logic [wid-1:0] sel_addr;
  logic [wid-1:0] sel_wdata;
  logic [3:0]     sel_be;

  // Access decode
  logic [wid-3:0] word_idx;
  logic           out_of_range;
  logic [wid-1:0] merged_word;

  // Control from the FSM
  logic           resp_fire;     // response registers load this cycle
  logic           resp_err;
  logic           rd_load;       // capture mem_rd as read data
  logic           merge_load;    // capture mem_rd for the merge step
  logic           mem_we_c;
  logic [wid-1:0] mem_wd_c;

  // Per-requester response outputs
  logic [1:0]     rvalid_vec;
  logic [1:0]     err_vec;
  logic [wid-1:0] rdata_vec [2];

  assign req_vec = {m1.req, m0.req};

  // Winner mux: grant_owner selects which bundle's fields get latched.
  assign sel_we    = grant_owner ? m1.we    : m0.we;
  assign sel_addr  = grant_owner ? m1.addr  : m0.addr;
  assign sel_wdata = grant_owner ? m1.wdata : m0.wdata;
  assign sel_be    = grant_owner ? m1.be    : m0.be;

  assign word_idx     = addr_reg[wid-1:2];
  assign out_of_range = (word_idx >= dep_idx);

  // Byte-lane merge for sub-word stores: new byte where enabled, else old.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[gi*8 +: 8] = be_reg[gi] ? wdata_reg[gi*8 +: 8]
                                               : merge_reg[gi*8 +: 8];
  end

  // ---------------------------------------------------------------------------
  // State register and latched transaction
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_last_reg <= 1'b1;   // so m0 wins the first tie
      owner_reg   <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
      merge_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        rr_last_reg <= grant_owner;
        owner_reg   <= grant_owner;
        we_reg      <= sel_we;
        addr_reg    <= sel_addr;
        wdata_reg   <= sel_wdata;
        be_reg      <= sel_be;
      end
      if (merge_load) begin
        merge_reg <= mem_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    grant       = 1'b0;
    grant_owner = 1'b0;
    gnt_vec     = 2'b00;
    resp_fire   = 1'b0;
    resp_err    = 1'b0;
    rd_load     = 1'b0;
    merge_load  = 1'b0;
    mem_we_c    = 1'b0;
    mem_wd_c    = '0;

    unique case (state_reg)
      IDLE: begin
        // Grants are suppressed while reset is asserted so a held request
        // cannot see a stray pulse.
        if (rst_n && (req_vec != 2'b00)) begin
          grant = 1'b1;
          if (req_vec == 2'b11) begin
            grant_owner = ~rr_last_reg;
          end else begin
            grant_owner = req_vec[1];
          end
          gnt_vec[0] = ~grant_owner;
          gnt_vec[1] = grant_owner;
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        state_next = IDLE;
        if (out_of_range) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else if (!we_reg) begin
          resp_fire = 1'b1;
          rd_load   = 1'b1;
        end else if (be_reg == 4'hF) begin
          mem_we_c  = 1'b1;
          mem_wd_c  = wdata_reg;
          resp_fire = 1'b1;
        end else if (be_reg == 4'h0) begin
          // Nothing to write; acknowledge only.
          resp_fire = 1'b1;
        end else begin
          merge_load = 1'b1;
          state_next = MERGE;
        end
      end

      MERGE: begin
        mem_we_c   = 1'b1;
        mem_wd_c   = merged_word;
        resp_fire  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered responses, one set per requester. Only the owner of the
  // finishing transaction sees rvalid; rdata otherwise holds.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    localparam logic me = (gi == 1);

    logic           rvalid_reg;
    logic           err_reg;
    logic [wid-1:0] rdata_reg;
    logic           mine;

    assign mine = resp_fire && (owner_reg == me);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        err_reg    <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= mine;
        err_reg    <= mine && resp_err;
        if (mine && resp_err) begin
          rdata_reg <= '0;
        end else if (mine && rd_load) begin
          rdata_reg <= mem_rd;
        end
      end
    end

    assign rvalid_vec[gi] = rvalid_reg;
    assign err_vec[gi]    = err_reg;
    assign rdata_vec[gi]  = rdata_reg;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m0.gnt    = gnt_vec[0];
  assign m1.gnt    = gnt_vec[1];
  assign m0.rvalid = rvalid_vec[0];
  assign m1.rvalid = rvalid_vec[1];
  assign m0.err    = err_vec[0];
  assign m1.err    = err_vec[1];
  assign m0.rdata  = rdata_vec[0];
  assign m1.rdata  = rdata_vec[1];

  // Address stays on the latched request; it is what the combinational read
  // port looks at during ACCESS.
  assign mem_addr = addr_reg;

  // Write strobe is masked by reset so a transaction aborted mid-flight never
  // reaches the memory.
  assign mem_we = mem_we_c & rst_n;
  assign mem_wd = rst_n ? mem_wd_c : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural single-port memory.
//   Stimulus pushes expected responses into a scoreboard queue; a monitor
//   pops and compares whenever an rvalid is seen.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int wid = 32;
  localparam int dep = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [wid-1:0] mem_addr;
  logic [wid-1:0] mem_wd;
  logic           mem_we;
  logic [wid-1:0] mem_rd;

  dmem_arbiter_if #(.wid(wid)) m0_bus ();
  dmem_arbiter_if #(.wid(wid)) m1_bus ();

  dmem_arbiter #(.wid(wid), .dep(dep)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  // Behavioural memory; out-of-range reads return a marker that must never
  // show up as response data.
  logic [31:0] mem [dep];
  logic        pl_we = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_val = '0;

  assign mem_rd = (mem_addr[31:8] == 24'd0) ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_we && (mem_addr[31:8] == 24'd0)) mem[mem_addr[7:2]] <= mem_wd;
    if (pl_we) mem[pl_idx] <= pl_val;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          owner;
    bit          err;
    bit          chk_data;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  int we_cnt = 0;
  int we_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: write-strobe log, grant exclusivity, scoreboard compare
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    bit   own;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_cyc = cyc;
      end
      if (m0_bus.gnt || m1_bus.gnt) begin
        chk("gnt_exclusive", {31'd0, m0_bus.gnt & m1_bus.gnt}, 32'd0);
      end
      if (m0_bus.rvalid || m1_bus.rvalid) begin
        chk("rvalid_exclusive", {31'd0, m0_bus.rvalid & m1_bus.rvalid}, 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b expected none", m0_bus.rvalid, m1_bus.rvalid);
        end else begin
          e   = sb_q.pop_front();
          own = m1_bus.rvalid;
          $display("resp owner=m%0d err=%0b rdata=0x%08h cycle=%0d", own,
                   own ? m1_bus.err : m0_bus.err, own ? m1_bus.rdata : m0_bus.rdata, cyc);
          chk("resp_owner", {31'd0, own}, {31'd0, e.owner});
          chk("resp_err", {31'd0, own ? m1_bus.err : m0_bus.err}, {31'd0, e.err});
          chk("resp_cycle", cyc, e.due);
          if (e.chk_data) chk("resp_rdata", own ? m1_bus.rdata : m0_bus.rdata, e.rdata);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic preload(input int idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_we  = 1'b1;
    @(posedge clk);
    #1;
    pl_we  = 1'b0;
  endtask

  task automatic drive(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input bit req);
    if (port) begin
      m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata; m1_bus.be = be; m1_bus.req = req;
    end else begin
      m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata; m0_bus.be = be; m0_bus.req = req;
    end
  endtask

  // Issue one request (called just after a rising edge) and push its expected
  // response once the grant is observed. Returns the grant cycle.
  task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input bit exp_err, input bit chk_data, input logic [31:0] exp_rd,
                        input int lat, output int gcyc);
    exp_t e;
    drive(port, we, addr, wdata, be, 1'b1);
    gcyc = -1;
    for (int i = 0; i < 50 && gcyc < 0; i++) begin
      @(negedge clk);
      if (port ? m1_bus.gnt : m0_bus.gnt) gcyc = cyc;
    end
    checks++;
    if (gcyc < 0) begin
      errors++;
      $display("FAIL gnt_timeout: got no gnt for m%0d expected gnt within 50 cycles", port);
    end else begin
      $display("req m%0d we=%0b addr=0x%08h wdata=0x%08h be=%h gnt cycle=%0d", port, we, addr, wdata, be, gcyc);
      e.owner = port; e.err = exp_err; e.chk_data = chk_data; e.rdata = exp_rd; e.due = gcyc + lat;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
    drive(port, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending responses expected 0", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_m0_gnt",    {31'd0, m0_bus.gnt},    32'd0);
    chk("rst_m1_gnt",    {31'd0, m1_bus.gnt},    32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_bus.rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_bus.rvalid}, 32'd0);
    chk("rst_m0_err",    {31'd0, m0_bus.err},    32'd0);
    chk("rst_m1_err",    {31'd0, m1_bus.err},    32'd0);
    chk("rst_m0_rdata",  m0_bus.rdata, 32'd0);
    chk("rst_m1_rdata",  m1_bus.rdata, 32'd0);
    chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_wd",    mem_wd, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int g;
    int w0;
    int n;
    int prev;
    bit own;
    exp_t e;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    preload(2, 32'hDEAD_BEEF);
    preload(4, 32'h0000_0000);
    preload(5, 32'hAABB_CCDD);
    preload(6, 32'h1122_3344);
    preload(7, 32'h5566_7788);
    do_reset();

    // m0 read of word 2
    do_req(1'b0, 1'b0, 32'h8, 32'd0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2, g);
    wait_drain("read");

    // m1 full-word write to word 4
    w0 = we_cnt;
    do_req(1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'd0, 2, g);
    wait_drain("full_write");
    chk("full_write_we_count", we_cnt - w0, 32'd1);
    chk("full_write_we_cycle", we_cyc, g + 1);
    chk("full_write_mem", mem[4], 32'h1234_5678);

    // m0 byte-1 write to word 5 (read-modify-write)
    w0 = we_cnt;
    do_req(1'b0, 1'b1, 32'h14, 32'h0000_1100, 4'b0010, 1'b0, 1'b0, 32'd0, 3, g);
    wait_drain("partial_write");
    chk("partial_we_count", we_cnt - w0, 32'd1);
    chk("partial_we_cycle", we_cyc, g + 2);
    chk("partial_mem", mem[5], 32'hAABB_11DD);

    // m1 read out of range (index 64)
    w0 = we_cnt;
    do_req(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b1, 1'b1, 32'd0, 2, g);
    wait_drain("oob_read");
    chk("oob_we_count", we_cnt - w0, 32'd0);

    // m1 write with no byte enables: ack only
    w0 = we_cnt;
    do_req(1'b1, 1'b1, 32'h1C, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 32'd0, 2, g);
    wait_drain("noop_write");
    chk("noop_we_count", we_cnt - w0, 32'd0);
    chk("noop_mem", mem[7], 32'h5566_7788);

    // Round robin: both held from reset, grants m0,m1,m0,m1 every 2 cycles
    do_reset();
    drive(1'b0, 1'b0, 32'h8,  32'd0, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    n = 0;
    prev = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (m0_bus.gnt || m1_bus.gnt) begin
        own = m1_bus.gnt;
        $display("rr gnt m%0d cycle=%0d", own, cyc);
        chk("rr_order", {31'd0, own}, {31'd0, n[0]});
        if (n > 0) chk("rr_spacing", cyc - prev, 32'd2);
        e.owner = own; e.err = 1'b0; e.chk_data = 1'b1;
        e.rdata = own ? 32'h1234_5678 : 32'hDEAD_BEEF;
        e.due = cyc + 2;
        sb_q.push_back(e);
        prev = cyc;
        n++;
      end
    end
    chk("rr_grant_count", n, 32'd4);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    wait_drain("round_robin");

    // Reset asserted while a partial write is in MERGE
    w0 = we_cnt;
    drive(1'b0, 1'b1, 32'h18, 32'h0000_00FF, 4'b0001, 1'b1);
    g = -1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      @(negedge clk);
      if (m0_bus.gnt) g = cyc;
    end
    chk("merge_reset_gnt_seen", {31'd0, g >= 0}, 32'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("merge_reset_we_count", we_cnt - w0, 32'd0);
    chk("merge_reset_mem", mem[6], 32'h1122_3344);
    do_req(1'b0, 1'b0, 32'h18, 32'd0, 4'h0, 1'b0, 1'b1, 32'h1122_3344, 2, g);
    wait_drain("after_reset_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
